// File: rtl/button_debounce_if.sv
// Signal bundle between a push-button conditioner and its consumer: raw synchronised
// level in, debounced level and one-cycle strobes out, plus the FSM state for observation.
interface button_debounce_if;
  logic       sig_in;
  logic       level_out;
  logic       rise_out;
  logic       fall_out;
  logic       long_out;
  logic [1:0] state_dbg;

  // No handshake: sig_in is sampled every clock edge, and each strobe is valid for
  // exactly the one cycle it is high. There is no ready/backpressure path.
  modport master (
    output sig_in,
    input  level_out, rise_out, fall_out, long_out, state_dbg
  );

  modport slave (
    input  sig_in,
    output level_out, rise_out, fall_out, long_out, state_dbg
  );
endinterface

// File: rtl/button_debounce.sv
// Debounces an already-synchronised button level and produces a clean level, rise and
// fall strobes, and a single long-press strobe timed from the rise.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  button_debounce_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          r_long;

  logic          w_hold_inc;
  logic [HW-1:0] w_hold_next;
  logic          w_long_hit;

  // hold saturates at LONG_CYCLES, so the strobe can only fire on the edge it gets there
  assign w_hold_inc  = (LONG_CYCLES > 0) && (r_hold != HOLD_MAX);
  assign w_hold_next = r_hold + HW'(1);
  assign w_long_hit  = w_hold_inc && (w_hold_next == HOLD_MAX);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_long <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (bus.sig_in) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= S_HIGH;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
              r_hold  <= '0;
              r_cnt   <= '0;
            end else begin
              r_state <= S_WAIT_HIGH;
              r_cnt   <= CW'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (bus.sig_in) begin
            if (r_cnt == CNT_LAST) begin
              r_state <= S_HIGH;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
              r_hold  <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end
        end
        S_HIGH: begin
          if (!bus.sig_in && (DEBOUNCE_CYCLES == 1)) begin
            // completed release wins over a long press landing on the same edge
            r_state <= S_LOW;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_hold  <= '0;
            r_cnt   <= '0;
          end else begin
            if (!bus.sig_in) begin
              r_state <= S_WAIT_LOW;
              r_cnt   <= CW'(1);
            end else begin
              r_cnt <= '0;
            end
            if (w_hold_inc) r_hold <= w_hold_next;
            r_long <= w_long_hit;
          end
        end
        S_WAIT_LOW: begin
          if (!bus.sig_in && (r_cnt == CNT_LAST)) begin
            r_state <= S_LOW;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_hold  <= '0;
            r_cnt   <= '0;
          end else begin
            if (!bus.sig_in) begin
              r_cnt <= r_cnt + CW'(1);
            end else begin
              r_state <= S_HIGH;
              r_cnt   <= '0;
            end
            // bounce during release keeps the press timer running
            if (w_hold_inc) r_hold <= w_hold_next;
            r_long <= w_long_hit;
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
          r_hold  <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_out = r_level;
  assign bus.rise_out  = r_rise;
  assign bus.fall_out  = r_fall;
  assign bus.long_out  = r_long;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_button_debounce.sv
// Drives two conditioners (N=4/L=10 and N=1/L=0) with the same button stream and compares
// every cycle against a run-length reference model of the debounce and long-press rules.
module tb_button_debounce;

  localparam int N_A = 4;
  localparam int L_A = 10;
  localparam int N_B = 1;
  localparam int L_B = 0;

  logic clk;
  logic rst_n;
  logic sig;

  int total;
  int bad;
  int cyc;

  button_debounce_if if_a ();
  button_debounce_if if_b ();

  assign if_a.sig_in = sig;
  assign if_b.sig_in = sig;

  button_debounce #(.DEBOUNCE_CYCLES(N_A), .LONG_CYCLES(L_A)) dut_a (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (if_a.slave)
  );

  button_debounce #(.DEBOUNCE_CYCLES(N_B), .LONG_CYCLES(L_B)) dut_b (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (if_b.slave)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: level flips once N consecutive samples disagree with it;
  // long press fires when the level is still high exactly L edges after the rise edge
  int m_lvl  [2];
  int m_rval [2];
  int m_rlen [2];
  int m_redge[2];
  int m_edge;

  logic [7:0] exp_q[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lvl[k]   = 0;
      m_rval[k]  = 0;
      m_rlen[k]  = 0;
      m_redge[k] = -100000;
    end
  endtask

  task automatic model_one(input int k, input int n, input int l, input int s,
                           output logic [3:0] e);
    logic rise, fall, lng;
    rise = 1'b0;
    fall = 1'b0;
    lng  = 1'b0;
    if (m_rlen[k] > 0 && m_rval[k] == s) m_rlen[k]++;
    else begin
      m_rval[k] = s;
      m_rlen[k] = 1;
    end
    if (s != m_lvl[k] && m_rlen[k] >= n) begin
      m_lvl[k] = s;
      if (s == 1) begin
        rise = 1'b1;
        m_redge[k] = m_edge;
      end else begin
        fall = 1'b1;
      end
    end
    if (l > 0 && m_lvl[k] == 1 && !rise && (m_edge - m_redge[k]) == l) lng = 1'b1;
    e = {(m_lvl[k] == 1), rise, fall, lng};
  endtask

  task automatic model_step(input logic s, input logic r);
    logic [3:0] ea, eb;
    if (!r) begin
      model_reset();
      exp_q.push_back(8'h00);
    end else begin
      m_edge++;
      model_one(0, N_A, L_A, int'(s), ea);
      model_one(1, N_B, L_B, int'(s), eb);
      exp_q.push_back({ea, eb});
    end
  endtask

  // checking task
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got{lvl,rise,fall,long}=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] obs_a();
    return {if_a.level_out, if_a.rise_out, if_a.fall_out, if_a.long_out};
  endfunction

  function automatic logic [3:0] obs_b();
    return {if_b.level_out, if_b.rise_out, if_b.fall_out, if_b.long_out};
  endfunction

  // driver: present sample away from the active edge, then score the edge's result
  task automatic step(input logic s, input logic r);
    logic [7:0] e;
    @(negedge clk);
    sig   = s;
    rst_n = r;
    @(posedge clk);
    #1;
    cyc++;
    model_step(s, r);
    e = exp_q.pop_front();
    check("dut_a", obs_a(), e[7:4]);
    check("dut_b", obs_b(), e[3:0]);
  endtask

  task automatic run(input logic s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b1);
  endtask

  task automatic pattern(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1);
  endtask

  // reset asserted between edges must clear outputs with no clock edge
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_a", obs_a(), 4'b0000);
    check("async_b", obs_b(), 4'b0000);
  endtask

  int rises_a;

  initial begin
    total  = 0;
    bad    = 0;
    cyc    = 0;
    m_edge = 0;
    model_reset();
    rst_n  = 1'b0;
    sig    = 1'b1;

    // reset held with button pressed
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    // release reset with button still down: rise on 4th edge
    run(1'b1, 6);
    run(1'b0, 6);

    // clean press
    run(1'b1, 5);
    run(1'b0, 5);

    // glitch rejection then a real press
    pattern(16'b1110_1110, 8);
    run(1'b1, 4);
    // hold 8 then bouncy release: long at edge 10, fall on 4th zero of final run
    run(1'b1, 8);
    pattern(16'b0010_000, 7);
    run(1'b0, 4);

    // release completing on the 10th edge after rise
    run(1'b1, 4);
    run(1'b1, 6);
    run(1'b0, 4);
    run(1'b0, 12);

    // mid-count reset during debounce of a press
    run(1'b1, 3);
    async_reset();
    step(1'b1, 1'b0);
    run(1'b1, 6);
    // reset while level is high
    async_reset();
    check("async_lvl", {3'b000, if_a.level_out}, 4'b0000);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run(1'b1, 5);
    run(1'b0, 6);

    // randomized bursts, with occasional long holds and rare reset pulses
    rises_a = 0;
    for (int b = 0; b < 250; b++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 16) : $urandom_range(1, 6);
      if ($urandom_range(0, 60) == 0) begin
        step(v, 1'b0);
      end else begin
        for (int i = 0; i < len; i++) begin
          step(v, 1'b1);
          if (if_a.rise_out) rises_a++;
        end
      end
    end
    check("rand_rises_seen", {3'b000, (rises_a > 0)}, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case of a stuck simulation
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
